// File: rtl/zbus_sink.sv
// zbus_sink: consuming end of a zbus link with programmable backpressure and sequence checker
// Ports:
//   z_clk, z_rst        clock and synchronous active-high reset
//   z_vld, z_bus        upstream valid and payload
//   z_ack               registered acknowledge (never combinational on z_vld)
//   cfg_en, cfg_mode    enable and ack pattern (00 always, 01 LFSR, 10 duty, 11 stall)
//   cfg_on, cfg_off     duty-mode ack-high / ack-low cycles per period
//   clr                 synchronous clear of statistics and expected value
//   trn_cnt, err_cnt    accepted transfers (wrapping) and mismatches (saturating)
//   err, err_exp, err_got  sticky mismatch flag and first-mismatch capture
// Build option: define ZBUS_SINK_RESYNC_EN to re-lock the expected value to the
// incoming word after a mismatch.
module zbus_sink #(
    parameter int          BW   = 8,
    parameter int          CW   = 16,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic          z_clk,
    input  logic          z_rst,
    input  logic          z_vld,
    input  logic [BW-1:0] z_bus,
    output logic          z_ack,
    input  logic          cfg_en,
    input  logic [1:0]    cfg_mode,
    input  logic [7:0]    cfg_on,
    input  logic [7:0]    cfg_off,
    input  logic          clr,
    output logic [CW-1:0] trn_cnt,
    output logic [CW-1:0] err_cnt,
    output logic          err,
    output logic [BW-1:0] err_exp,
    output logic [BW-1:0] err_got
);
    typedef enum logic {ON, OFF} duty_t;

    // an all-zero seed would lock the LFSR up
    localparam logic [15:0] SEED_I = (SEED == 16'h0000) ? 16'h0001 : SEED;

    duty_t         st, st_nxt;
    logic [7:0]    cnt, cnt_nxt, on_lim;
    logic [8:0]    cnt_inc;
    logic [15:0]   lfsr, lfsr_nxt;
    logic          lfsr_run, duty_run, ack_nxt, trn, mis;
    logic [BW-1:0] exp_val, exp_nxt;

    always_comb begin
        lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        lfsr_run = cfg_en && cfg_mode == 2'b01;
        duty_run = cfg_en && cfg_mode == 2'b10;
        on_lim   = (cfg_on == 8'd0) ? 8'd1 : cfg_on;
        cnt_inc  = {1'b0, cnt} + 9'd1;
        st_nxt   = ON;
        cnt_nxt  = 8'd0;
        if (duty_run) begin
            // >= rather than == so a limit lowered mid-phase cannot strand the counter
            if (st == ON) begin
                st_nxt  = (cnt_inc >= {1'b0, on_lim}) ? ((cfg_off == 8'd0) ? ON : OFF) : ON;
                cnt_nxt = (cnt_inc >= {1'b0, on_lim}) ? 8'd0 : cnt_inc[7:0];
            end else begin
                st_nxt  = (cnt_inc >= {1'b0, cfg_off}) ? ON : OFF;
                cnt_nxt = (cnt_inc >= {1'b0, cfg_off}) ? 8'd0 : cnt_inc[7:0];
            end
        end
        ack_nxt = !cfg_en              ? 1'b0 :
                  cfg_mode == 2'b00    ? 1'b1 :
                  cfg_mode == 2'b01    ? lfsr_nxt[0] :
                  cfg_mode == 2'b10    ? (st == ON) : 1'b0;
    end

    always_comb begin
        trn = z_vld & z_ack;
        mis = z_bus != exp_val;
`ifdef ZBUS_SINK_RESYNC_EN
        exp_nxt = mis ? z_bus + BW'(1) : exp_val + BW'(1);
`else
        exp_nxt = exp_val + BW'(1);
`endif
    end

    always_ff @(posedge z_clk) begin
        if (z_rst) begin
            st  <= ON;
            cnt <= 8'd0;
        end else begin
            st  <= st_nxt;
            cnt <= cnt_nxt;
        end
    end

    always_ff @(posedge z_clk) begin
        if (z_rst) begin
            z_ack   <= 1'b0;
            lfsr    <= SEED_I;
            exp_val <= '0;
            trn_cnt <= '0;
            err_cnt <= '0;
            err     <= 1'b0;
            err_exp <= '0;
            err_got <= '0;
        end else begin
            z_ack <= ack_nxt;
            if (lfsr_run)
                lfsr <= lfsr_nxt;
            if (clr) begin
                exp_val <= '0;
                trn_cnt <= '0;
                err_cnt <= '0;
                err     <= 1'b0;
                err_exp <= '0;
                err_got <= '0;
            end else if (trn) begin
                trn_cnt <= trn_cnt + CW'(1);
                exp_val <= exp_nxt;
                if (mis) begin
                    err_cnt <= (&err_cnt) ? err_cnt : err_cnt + CW'(1);
                    err     <= 1'b1;
                    if (!err) begin
                        err_exp <= exp_val;
                        err_got <= z_bus;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_zbus_sink.sv
// tb_zbus_sink: scoreboard bench for zbus_sink; stimulus queues expectations, a negedge monitor checks them
module tb_zbus_sink;
    logic        clk = 1'b0;
    logic        z_rst, z_vld, z_ack, cfg_en, clr, err;
    logic [7:0]  z_bus, cfg_on, cfg_off, err_exp, err_got;
    logic [1:0]  cfg_mode;
    logic [15:0] trn_cnt, err_cnt;

    typedef struct {
        string nm;
        int    trn;
        int    ec;
        int    e;
        int    ee;
        int    eg;
    } st_t;

    st_t  st_q[$];
    logic ack_q[$];
    int   checks = 0;
    int   errors = 0;

`ifdef ZBUS_SINK_RESYNC_EN
    localparam int DROP_ERRS = 1;
`else
    localparam int DROP_ERRS = 2;
`endif

    zbus_sink #(.BW(8), .CW(16), .SEED(16'hACE1)) dut (
        .z_clk(clk), .z_rst(z_rst), .z_vld(z_vld), .z_bus(z_bus), .z_ack(z_ack),
        .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_on(cfg_on), .cfg_off(cfg_off),
        .clr(clr), .trn_cnt(trn_cnt), .err_cnt(err_cnt), .err(err),
        .err_exp(err_exp), .err_got(err_got)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    always @(negedge clk) begin
        st_t  s;
        logic a;
        if (ack_q.size() > 0) begin
            a = ack_q.pop_front();
            chk("z_ack", int'(z_ack), int'(a));
        end
        if (st_q.size() > 0) begin
            s = st_q.pop_front();
            chk({s.nm, ".trn_cnt"}, int'(trn_cnt), s.trn);
            chk({s.nm, ".err_cnt"}, int'(err_cnt), s.ec);
            chk({s.nm, ".err"}, int'(err), s.e);
            chk({s.nm, ".err_exp"}, int'(err_exp), s.ee);
            chk({s.nm, ".err_got"}, int'(err_got), s.eg);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic want_st(input string nm, input int trn, input int ec, input int e,
                           input int ee, input int eg);
        st_t s;
        s.nm = nm; s.trn = trn; s.ec = ec; s.e = e; s.ee = ee; s.eg = eg;
        st_q.push_back(s);
    endtask

    task automatic send(input logic [7:0] w);
        int n = 0;
        z_vld = 1'b1;
        z_bus = w;
        while (!z_ack && n < 200) begin
            tick();
            n++;
        end
        if (!z_ack) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got=0 want=1");
        end
        tick();
    endtask

    task automatic stall_clr(input string nm);
        cfg_mode = 2'b11;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        ack_q.push_back(1'b0);
        want_st(nm, 0, 0, 0, 0, 0);
        tick();
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] n;
        logic        fb;
        fb = s[0];
        n = {fb, s[15:1]};
        n[13] = n[13] ^ fb;
        n[12] = n[12] ^ fb;
        n[10] = n[10] ^ fb;
        return n;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  w;
        logic [15:0] s;
        logic        acked, pe;
        int          ones;
        logic        duty_pat [5];
        duty_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        z_rst = 1'b1; z_vld = 1'b0; z_bus = 8'd0; clr = 1'b0;
        cfg_en = 1'b1; cfg_mode = 2'b00; cfg_on = 8'd2; cfg_off = 8'd3;
        tick();
        tick();
        ack_q.push_back(1'b0);
        want_st("reset", 0, 0, 0, 0, 0);
        z_rst = 1'b0;
        tick();
        ack_q.push_back(1'b1);
        for (int i = 0; i < 19; i++)
            send(8'(i));
        z_vld = 1'b0;
        want_st("always", 19, 0, 0, 0, 0);
        tick();

        stall_clr("clr_a");
        cfg_mode = 2'b10; z_vld = 1'b1; w = 8'd0; z_bus = w;
        for (int k = 1; k <= 25; k++) begin
            acked = z_ack;
            tick();
            if (acked) w++;
            z_bus = w;
            ack_q.push_back(duty_pat[(k - 1) % 5]);
        end
        z_vld = 1'b0;
        want_st("duty", 10, 0, 0, 0, 0);
        tick();

        stall_clr("clr_b");
        cfg_mode = 2'b01; z_vld = 1'b1; w = 8'd0; z_bus = w;
        s = 16'hACE1; pe = 1'b0; ones = 0;
        for (int k = 1; k <= 64; k++) begin
            ones += int'(pe);
            acked = z_ack;
            tick();
            if (acked) w++;
            z_bus = w;
            s = lfsr_step(s);
            ack_q.push_back(s[0]);
            pe = s[0];
        end
        z_vld = 1'b0;
        want_st("lfsr", ones, 0, 0, 0, 0);
        tick();

        cfg_mode = 2'b11; cfg_en = 1'b0;
        tick();
        ack_q.push_back(1'b0);
        cfg_en = 1'b1;
        stall_clr("clr_c");
        cfg_mode = 2'b00;
        tick();
        ack_q.push_back(1'b1);
        send(8'd0); send(8'd1); send(8'd2); send(8'd5); send(8'd6);
        z_vld = 1'b0;
        want_st("drop", 5, DROP_ERRS, 1, 3, 5);
        tick();

        clr = 1'b1;
        tick();
        clr = 1'b0;
        send(8'd5); send(8'd5); send(8'd5);
        z_vld = 1'b0;
        want_st("three_err", 3, 3, 1, 0, 5);
        z_vld = 1'b1; z_bus = 8'd9; clr = 1'b1;
        tick();
        clr = 1'b0; z_vld = 1'b0;
        want_st("clr_trn", 0, 0, 0, 0, 0);
        send(8'd0);
        z_vld = 1'b0;
        want_st("after_clr", 1, 0, 0, 0, 0);
        tick();

        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 256; i++)
            send(8'(i));
        send(8'd0);
        z_vld = 1'b0;
        want_st("wrap", 257, 0, 0, 0, 0);
        tick();

        z_vld = 1'b1; z_bus = 8'd1; z_rst = 1'b1;
        tick();
        ack_q.push_back(1'b0);
        want_st("mid_rst", 0, 0, 0, 0, 0);
        z_rst = 1'b0; z_bus = 8'd0;
        tick();
        ack_q.push_back(1'b1);
        want_st("rst_rel", 0, 0, 0, 0, 0);
        tick();
        ack_q.push_back(1'b1);
        want_st("rst_first", 1, 0, 0, 0, 0);
        z_vld = 1'b0;
        tick();
        tick();
        if (ack_q.size() != 0 || st_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL queue_drain got=%0d want=0", ack_q.size() + st_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
